// File: rtl/netlist_bist_pkg.sv
// Shared types, default widths and LFSR/MISR feedback helpers for the
// netlist self-test controller.
package netlist_bist_pkg;

  localparam int NUM_IN_DEF   = 14;
  localparam int NUM_OUT_DEF  = 8;
  localparam int SIG_W_DEF    = 16;
  localparam int CNT_W_DEF    = 16;
  localparam int SETTLE_W_DEF = 4;

  // Tap masks as bit positions: LFSR x^14+x^5+x^3+x^1, MISR x^16+x^15+x^13+x^4
  localparam logic [13:0] LFSR_TAPS = 14'h2015;
  localparam logic [15:0] MISR_TAPS = 16'hD008;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } bist_state_e;

  function automatic logic [13:0] lfsr_step(input logic [13:0] cur);
    return {cur[12:0], ^(cur & LFSR_TAPS)};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] cur,
                                            input logic [15:0] data);
    return {cur[14:0], ^(cur & MISR_TAPS)} ^ data;
  endfunction

endpackage

// File: rtl/netlist_bist_ctrl_misr.sv
// Multiple-input signature register compressing netlist responses.
import netlist_bist_pkg::*;

module bist_misr #(
  parameter int SIG_W = SIG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [SIG_W-1:0] data_in,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  // Next-signature selection: clear wins over a compress step
  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = misr_step(sig_q, data_in);
    end else begin
      sig_d = sig_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/netlist_bist_ctrl.sv
// BIST sequencer: LFSR patterns onto a combinational netlist, settle window,
// MISR compression of responses and golden-signature compare.
import netlist_bist_pkg::*;

module netlist_bist_ctrl #(
  parameter int NUM_IN   = NUM_IN_DEF,
  parameter int NUM_OUT  = NUM_OUT_DEF,
  parameter int SIG_W    = SIG_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int SETTLE_W = SETTLE_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    pattern_count,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic [NUM_IN-1:0]   seed,
  input  logic [SIG_W-1:0]    golden_sig,
  input  logic [NUM_OUT-1:0]  dut_out,
  output logic [NUM_IN-1:0]   dut_in,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [SIG_W-1:0]    signature,
  output logic [CNT_W-1:0]    patterns_done
);

  localparam logic [CNT_W-1:0]    CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [SETTLE_W-1:0] SETTLE_ONE = {{(SETTLE_W-1){1'b0}}, 1'b1};
  localparam logic [NUM_IN-1:0]   SEED_ONE   = {{(NUM_IN-1){1'b0}}, 1'b1};

  bist_state_e         state_q, state_d;
  logic [CNT_W-1:0]    n_q, n_d;
  logic [SETTLE_W-1:0] s_q, s_d;
  logic [NUM_IN-1:0]   seed_q, seed_d;
  logic [NUM_IN-1:0]   lfsr_q, lfsr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                misr_clr_s;
  logic                misr_en_s;
  logic [CNT_W-1:0]    cnt_inc_s;
  logic [SIG_W-1:0]    dut_out_ext_s;
  logic [SIG_W-1:0]    sig_s;

  // Zero-extend netlist outputs to the signature width
  always_comb begin
    dut_out_ext_s = '0;
    dut_out_ext_s[NUM_OUT-1:0] = dut_out;
  end

  // Next-state, datapath and registered-output decode; abort beats any busy transition
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    s_d        = s_q;
    seed_d     = seed_q;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    settle_d   = settle_q;
    misr_clr_s = 1'b0;
    misr_en_s  = 1'b0;
    cnt_inc_s  = cnt_q + CNT_ONE;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          n_d     = pattern_count;
          s_d     = settle_cycles;
          seed_d  = seed;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          lfsr_d     = (seed_q == '0) ? SEED_ONE : seed_q;
          misr_clr_s = 1'b1;
          cnt_d      = '0;
          settle_d   = '0;
          if (n_q == '0) begin
            state_d = ST_DONE;
          end else if (s_q == '0) begin
            state_d = ST_CAPTURE;
          end else begin
            state_d = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          settle_d = settle_q + SETTLE_ONE;
          if (settle_q == (s_q - SETTLE_ONE)) begin
            state_d = ST_CAPTURE;
          end else begin
            state_d = ST_SETTLE;
          end
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          misr_en_s = 1'b1;
          lfsr_d    = lfsr_step(lfsr_q);
          cnt_d     = cnt_inc_s;
          settle_d  = '0;
          if (cnt_inc_s == n_q) begin
            state_d = ST_DONE;
          end else if (s_q == '0) begin
            state_d = ST_CAPTURE;
          end else begin
            state_d = ST_SETTLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_LOAD) || (state_d == ST_SETTLE) || (state_d == ST_CAPTURE);
    done_d = (state_d == ST_DONE);
  end

  // State, latched run parameters, pattern generator and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      n_q      <= '0;
      s_q      <= '0;
      seed_q   <= '0;
      lfsr_q   <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      s_q      <= s_d;
      seed_q   <= seed_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  bist_misr #(
    .SIG_W (SIG_W)
  ) u_misr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (misr_clr_s),
    .en      (misr_en_s),
    .data_in (dut_out_ext_s),
    .sig     (sig_s)
  );

  assign dut_in        = lfsr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign signature     = sig_s;
  assign patterns_done = cnt_q;
  assign pass          = done_q & (sig_s == golden_sig);

endmodule

// File: tb/tb_netlist_bist_ctrl.sv
// Directed self-checking bench for netlist_bist_ctrl with hand-computed vectors.
`timescale 1ns/1ps
module tb_netlist_bist_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] pattern_count;
  logic [3:0]  settle_cycles;
  logic [13:0] seed;
  logic [15:0] golden_sig;
  logic [7:0]  dut_out;
  logic [13:0] dut_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
  logic [15:0] patterns_done;

  int checks;
  int failures;

  netlist_bist_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .pattern_count (pattern_count),
    .settle_cycles (settle_cycles),
    .seed          (seed),
    .golden_sig    (golden_sig),
    .dut_out       (dut_out),
    .dut_in        (dut_in),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .signature     (signature),
    .patterns_done (patterns_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // After return the start edge has passed and the FSM sits in LOAD.
  task automatic run_start(input logic [15:0] n, input logic [3:0] s, input logic [13:0] sd);
    pattern_count = n;
    settle_cycles = s;
    seed          = sd;
    start         = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_dut_in"}, 32'(dut_in), 32'h0);
    check_val({tag, "_busy"}, 32'(busy), 32'h0);
    check_val({tag, "_done"}, 32'(done), 32'h0);
    check_val({tag, "_pass"}, 32'(pass), 32'h0);
    check_val({tag, "_sig"}, 32'(signature), 32'h0);
    check_val({tag, "_pdone"}, 32'(patterns_done), 32'h0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    pattern_count = 16'd0;
    settle_cycles = 4'd0;
    seed = 14'd0;
    golden_sig = 16'h0000;
    dut_out = 8'h00;
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Zero seed becomes 1; one cycle per pattern; done 5 cycles after start
    run_start(16'd4, 4'd0, 14'h0000);
    step();
    check_val("t1_p0", 32'(dut_in), 32'h0001);
    check_val("t1_busy", 32'(busy), 32'h1);
    step();
    check_val("t1_p1", 32'(dut_in), 32'h0003);
    step();
    check_val("t1_p2", 32'(dut_in), 32'h0007);
    step();
    check_val("t1_p3", 32'(dut_in), 32'h000E);
    check_val("t1_notdone", 32'(done), 32'h0);
    step();
    check_val("t1_done", 32'(done), 32'h1);
    check_val("t1_busy_lo", 32'(busy), 32'h0);
    check_val("t1_pdone", 32'(patterns_done), 32'h4);

    // MISR compression and golden compare
    dut_out = 8'hA5;
    golden_sig = 16'h014A;
    run_start(16'd2, 4'd0, 14'h0001);
    step();
    step();
    check_val("t2_sig1", 32'(signature), 32'h00A5);
    dut_out = 8'h00;
    step();
    check_val("t2_sig2", 32'(signature), 32'h014A);
    check_val("t2_done", 32'(done), 32'h1);
    check_val("t2_pass", 32'(pass), 32'h1);
    golden_sig = 16'h014B;
    #1;
    check_val("t2_fail_cmp", 32'(pass), 32'h0);

    // Settle window S=3, N=3: 4 cycles per pattern, done at 13; mid-run start ignored
    dut_out = 8'h3C;
    run_start(16'd3, 4'd3, 14'h0005);
    for (int k = 1; k <= 13; k++) begin
      step();
      if (k == 6) start = 1'b1;
      if (k == 7) start = 1'b0;
      if (k == 1) check_val("t3_p0_first", 32'(dut_in), 32'h0005);
      if (k == 4) check_val("t3_p0_last", 32'(dut_in), 32'h0005);
      if (k == 5) check_val("t3_p1_first", 32'(dut_in), 32'h000A);
      if (k == 8) check_val("t3_p1_last", 32'(dut_in), 32'h000A);
      if (k == 9) check_val("t3_p2_first", 32'(dut_in), 32'h0014);
      if (k == 12) begin
        check_val("t3_busy12", 32'(busy), 32'h1);
        check_val("t3_notdone12", 32'(done), 32'h0);
      end
      if (k == 13) begin
        check_val("t3_done13", 32'(done), 32'h1);
        check_val("t3_pdone", 32'(patterns_done), 32'h3);
      end
    end
    check_val("t3_sig_nonzero", 32'(signature != 16'h0000), 32'h1);

    // N=0: one cycle to DONE, MISR cleared
    golden_sig = 16'h0000;
    run_start(16'd0, 4'd2, 14'h0009);
    check_val("t4_busy_load", 32'(busy), 32'h1);
    step();
    check_val("t4_done", 32'(done), 32'h1);
    check_val("t4_sig", 32'(signature), 32'h0);
    check_val("t4_pdone", 32'(patterns_done), 32'h0);
    check_val("t4_pass", 32'(pass), 32'h1);
    golden_sig = 16'h0001;
    #1;
    check_val("t4_pass_ne", 32'(pass), 32'h0);

    // Abort in 2nd settle cycle of pattern 2
    run_start(16'd3, 4'd2, 14'h0001);
    for (int k = 1; k <= 5; k++) step();
    check_val("t5_p1", 32'(dut_in), 32'h0003);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_val("t5_busy", 32'(busy), 32'h0);
    check_val("t5_done", 32'(done), 32'h0);
    check_val("t5_pdone", 32'(patterns_done), 32'h1);
    check_val("t5_frozen", 32'(dut_in), 32'h0003);
    // start and abort together in IDLE: start wins
    abort = 1'b1;
    run_start(16'd3, 4'd2, 14'h0001);
    check_val("t5_restart_busy", 32'(busy), 32'h1);
    step();
    check_val("t5_rerun_seed", 32'(dut_in), 32'h0001);
    check_val("t5_rerun_pdone", 32'(patterns_done), 32'h0);

    // Async reset mid-CAPTURE, then a clean rerun reproduces the signature
    dut_out = 8'hA5;
    golden_sig = 16'h014A;
    run_start(16'd2, 4'd0, 14'h0001);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_rst");
    #3;
    rst_n = 1'b1;
    step();
    run_start(16'd2, 4'd0, 14'h0001);
    step();
    step();
    dut_out = 8'h00;
    step();
    check_val("t6_sig", 32'(signature), 32'h014A);
    check_val("t6_pass", 32'(pass), 32'h1);
    check_val("t6_pdone", 32'(patterns_done), 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/netlist_bist_ctrl.md
# netlist_bist_ctrl

Self-test controller that sequences a mapped combinational netlist block (default 14 primary inputs, 8 primary outputs). It drives pseudo-random patterns from an LFSR onto the netlist inputs and holds each pattern for a programmable settling window. It then compresses the netlist outputs into a MISR signature and reports pass/fail against a golden signature. It sits between the test/config register interface and one netlist instance; the netlist itself is untouched.

## Interface
- NUM_IN, 14, netlist input width (LFSR width); only 14 supported
- NUM_OUT, 8, netlist output width; must be ≤ SIG_W
- SIG_W, 16, MISR/signature width; only 16 supported
- CNT_W, 16, pattern counter width
- SETTLE_W, 4, settle counter width
- clk  in  1  sole clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin run; sampled only in IDLE or DONE
- abort  in  1  terminate run; sampled in any busy state
- pattern_count  in  CNT_W  patterns per run (N), sampled at start
- settle_cycles  in  SETTLE_W  extra hold cycles per pattern (S), sampled at start
- seed  in  NUM_IN  LFSR seed, sampled at start
- golden_sig  in  SIG_W  expected signature, compared combinationally when done
- dut_out  in  NUM_OUT  netlist outputs
- dut_in  out  NUM_IN  netlist inputs (= LFSR register)
- busy  out  1  high in LOAD/SETTLE/CAPTURE
- done  out  1  high in DONE (level, held until next start)
- pass  out  1  done & (signature == golden_sig); 0 otherwise
- signature  out  SIG_W  MISR register
- patterns_done  out  CNT_W  capture count of current/last run

## Operation
- States: IDLE, LOAD, SETTLE, CAPTURE, DONE.
- IDLE/DONE + start → LOAD.
  - Latch N, S, seed.
  - DONE keeps the previous signature, pass and patterns_done until LOAD.
- LOAD:
  - lfsr ← seed; a zero seed is replaced by 1.
  - misr ← 0, patterns_done ← 0, settle_cnt ← 0.
  - Next state: N=0 → DONE; S=0 → CAPTURE; else → SETTLE.
- SETTLE: settle_cnt increments; when settle_cnt == S−1 → CAPTURE.
- CAPTURE:
  - misr ← {misr[14:0], fb_m} ^ zero-extend(dut_out), where fb_m = misr[15]^misr[14]^misr[12]^misr[3].
  - lfsr ← {lfsr[12:0], fb_l}, where fb_l = lfsr[13]^lfsr[4]^lfsr[2]^lfsr[0].
  - patterns_done increments; settle_cnt ← 0.
  - If the incremented count == N → DONE; else → SETTLE (S>0) or stay in CAPTURE (S=0).
- abort in LOAD/SETTLE/CAPTURE → IDLE next edge. In that case done stays 0, and signature/patterns_done freeze at their current values.
- abort has priority over any same-cycle transition. start while busy is ignored. start and abort together in IDLE/DONE: start wins (abort has no meaning there).
- patterns_done saturates naturally because N ≤ 2^CNT_W−1; no wrap occurs within a run.

## Timing
- Reset values: state IDLE, dut_in 0, busy 0, done 0, pass 0, signature 0, patterns_done 0.
- Each pattern is stable on dut_in for exactly S+1 cycles. The MISR samples dut_out on the edge ending that window, the same edge that advances dut_in.
- done rises N·(S+1)+1 cycles after the edge that samples start; N=0 gives 1 cycle.
- All outputs are registered except pass, which is a combinational compare gated by the done register.
- Reset asserted mid-run returns every output to its reset value immediately (asynchronously), with no partial done.

## Structure
- Package netlist_bist_pkg holds:
  - state enum
  - LFSR tap constant (14,5,3,1) and MISR tap constant (16,15,13,4)
  - default widths
- One sub-module, bist_misr: SIG_W signature register with clear, enable and parallel data input.
- LFSR, counters and FSM stay inline in netlist_bist_ctrl.

## Test plan
- Seed 0, N=4, S=0 → dut_in sequence 0x0001, 0x0003, 0x0007, 0x000E (one cycle each); done at cycle 5; patterns_done=4.
- Seed 1, N=2, S=0, dut_out=0xA5 then 0x00 → signature 0x00A5, then 0x014A; golden_sig=0x014A gives pass=1, 0x014B gives pass=0.
- S=3, N=3 → each dut_in value held 4 cycles; done rises 13 cycles after start; busy high throughout.
- N=0 → LOAD then DONE after 1 cycle; signature 0; pass = (golden_sig == 0).
- abort in the 2nd SETTLE cycle of pattern 2 → IDLE next edge, done 0, patterns_done=1. A following start reruns from the seed.
- rst_n low mid-CAPTURE → all outputs 0 immediately. A restart after release reproduces the clean-run signature.
